// File: rtl/ccsds123_sample_packer.sv
// Packs PIPELINES consecutive D-bit samples into one word for ccsds123_top, flushing a zero-padded word at image end.
// Optional m_axis_tlast end-of-image flag is enabled by defining CCSDS_PACKER_TLAST_EN.
module ccsds123_sample_packer #(
   parameter int PIPELINES = 2,
   parameter int D         = 16,
   parameter int NX        = 16,
   parameter int NY        = 16,
   parameter int NZ        = 8
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [D-1:0]           s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [PIPELINES*D-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready
`ifdef CCSDS_PACKER_TLAST_EN
   ,
   output logic                   m_axis_tlast
`endif
);

   localparam int TOTAL = NX * NY * NZ;
   localparam int W     = PIPELINES * D;
   localparam int LW    = (PIPELINES > 1) ? $clog2(PIPELINES) : 1;
   localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [LW-1:0] LANE_LAST = LW'(PIPELINES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(TOTAL - 1);

   logic [LW-1:0] lane, lane_nxt;
   logic [IW-1:0] sample_idx, idx_nxt;
   logic [W-1:0]  acc, acc_nxt;
   logic [W-1:0]  merged;
   logic [W-1:0]  out_data, out_data_nxt;
   logic          out_valid, out_valid_nxt;
   logic          out_last, out_last_nxt;
   logic          close;
   logic          accept;

   // The incoming sample closes the word on the last lane or on the last sample of the image.
   always_comb begin
      close         = (lane == LANE_LAST) || (sample_idx == IDX_LAST);
      s_axis_tready = aresetn && (!close || !out_valid || m_axis_tready);
      accept        = s_axis_tvalid && s_axis_tready;
   end

   // Lanes below the current one come from the accumulator, lanes above are forced to zero.
   always_comb begin
      merged = '0;
      for (int unsigned k = 0; k < PIPELINES; k++) begin
         if (k < 32'(lane))
            merged[k*D +: D] = acc[k*D +: D];
         else if (k == 32'(lane))
            merged[k*D +: D] = s_axis_tdata;
      end
   end

   always_comb begin
      lane_nxt      = lane;
      idx_nxt       = sample_idx;
      acc_nxt       = acc;
      out_data_nxt  = out_data;
      out_valid_nxt = out_valid;
      out_last_nxt  = out_last;
      if (out_valid && m_axis_tready)
         out_valid_nxt = 1'b0;
      if (accept) begin
         idx_nxt = (sample_idx == IDX_LAST) ? '0 : sample_idx + IW'(1);
         if (close) begin
            // A reload in the same cycle as a drain overrides the clear above.
            out_data_nxt  = merged;
            out_valid_nxt = 1'b1;
            out_last_nxt  = (sample_idx == IDX_LAST);
            acc_nxt       = '0;
            lane_nxt      = '0;
         end else begin
            acc_nxt  = merged;
            lane_nxt = lane + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         lane       <= '0;
         sample_idx <= '0;
         acc        <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         lane       <= lane_nxt;
         sample_idx <= idx_nxt;
         acc        <= acc_nxt;
         out_data   <= out_data_nxt;
         out_valid  <= out_valid_nxt;
         out_last   <= out_last_nxt;
      end
   end

   assign m_axis_tdata  = out_data;
   assign m_axis_tvalid = out_valid;
`ifdef CCSDS_PACKER_TLAST_EN
   assign m_axis_tlast  = out_last;
`else
   logic unused_last;
   assign unused_last = out_last;
`endif

endmodule
